// File: rtl/simon_pkg.sv
// Shared types, sizes and constants for the Simon 64/96 decrypt core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package simon_pkg;

    localparam int WORD_SIZE = 32;
    localparam int KEY_WORDS = 3;
    localparam int CONST_SEQ = 2;
    localparam int N_ROUNDS  = 42;
    localparam int IDX_W     = $clog2(N_ROUNDS);

    typedef logic [WORD_SIZE-1:0]                 rkey_t;
    typedef logic [KEY_WORDS-1:0][WORD_SIZE-1:0]  key_t;
    typedef logic [IDX_W-1:0]                     idx_t;

    // l occupies the upper half of the block, r the lower half.
    typedef struct packed {
        rkey_t l;
        rkey_t r;
    } data_t;

    typedef enum logic [2:0] {
        NOKEY,
        EXPAND,
        READY,
        DECRYPT,
        DONE
    } simon_dec_state_t;

    // z-sequences written in their published order: the leftmost digit is
    // element 0, so element j lives at bit 61-j of each literal.
    localparam logic [61:0] Z_SEQ [0:4] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    localparam logic [61:0] Z_CUR = Z_SEQ[CONST_SEQ];

    function automatic logic z_bit(input logic [5:0] j);
        return Z_CUR[6'd61 - j];
    endfunction

    function automatic rkey_t rol(input rkey_t v, input int s);
        return (v << s) | (v >> (WORD_SIZE - s));
    endfunction

    function automatic rkey_t ror(input rkey_t v, input int s);
        return (v >> s) | (v << (WORD_SIZE - s));
    endfunction

endpackage

// File: rtl/simon_key_expand.sv
// Simon key schedule: holds the N_ROUNDS round-key store and fills it one key per step.
// Latency: load writes the master words in one cycle; each step writes one further key.
// Backpressure: none; the caller asserts step only while expanding and watches last.
// Ports: clk, rst (sync, active high), load/key_in (master key), step (write next key),
//        last (current step writes the final key), rd_idx/rd_key (round-key read port).
// Build option: SIMON_DEC_ZEROIZE_EN adds a reset that clears the whole store.
module simon_key_expand
    import simon_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  key_t  key_in,
    input  logic  step,
    output logic  last,
    input  idx_t  rd_idx,
    output rkey_t rd_key
);

    rkey_t      rk [N_ROUNDS];
    idx_t       wr_idx;
    idx_t       i1, i3, im, zoff;
    logic [5:0] zj;
    rkey_t      tmp, nxt;

    assign last   = (wr_idx == idx_t'(N_ROUNDS - 1));
    assign rd_key = rk[rd_idx];

    always_comb begin
        i1   = wr_idx - idx_t'(1);
        i3   = wr_idx - idx_t'(3);
        im   = wr_idx - idx_t'(KEY_WORDS);
        zoff = wr_idx - idx_t'(KEY_WORDS);
        zj   = 6'(int'(zoff) % 62);
        tmp  = ror(rk[i1], 3);
        if (KEY_WORDS == 4) begin
            tmp = tmp ^ rk[i3];
        end
        tmp = tmp ^ ror(tmp, 1);
        nxt = ~rk[im] ^ tmp ^ rkey_t'(z_bit(zj)) ^ rkey_t'(3);
    end

    // Write pointer needs no reset: every expansion starts with load.
    always_ff @(posedge clk) begin
        if (load) begin
            wr_idx <= idx_t'(KEY_WORDS);
        end else if (step && !last) begin
            wr_idx <= wr_idx + idx_t'(1);
        end
    end

    always_ff @(posedge clk) begin
`ifdef SIMON_DEC_ZEROIZE_EN
        if (rst) begin
            for (int k = 0; k < N_ROUNDS; k++) begin
                rk[k] <= '0;
            end
        end else
`endif
        if (load) begin
            for (int k = 0; k < KEY_WORDS; k++) begin
                rk[k] <= key_in[k];
            end
        end else if (step) begin
            rk[wr_idx] <= nxt;
        end
    end

endmodule

// File: rtl/simon_decrypt.sv
// Simon 64/96 block decrypt: key load + expansion, then one inverse round per cycle.
// Latency: key expansion N_ROUNDS-KEY_WORDS cycles; block N_ROUNDS cycles accept-to-out_valid.
// Backpressure: result held in DONE while out_ready=0; in_ready low outside READY.
// Ports: clk, rst (sync, active high), key_in/key_load/key_ready (key path),
//        in_data/in_valid/in_ready (ciphertext), out_data/out_valid/out_ready (plaintext).
// Build option: SIMON_DEC_ZEROIZE_EN clears keys and datapath on reset, clears (x,y)
//               after each result, and forces out_data to 0 whenever out_valid is low.
module simon_decrypt
    import simon_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  key_t  key_in,
    input  logic  key_load,
    output logic  key_ready,
    input  data_t in_data,
    input  logic  in_valid,
    output logic  in_ready,
    output data_t out_data,
    output logic  out_valid,
    input  logic  out_ready
);

    simon_dec_state_t state, state_nxt;
    idx_t             r;
    rkey_t            x, y;
    rkey_t            rk_cur;
    rkey_t            f_y;
    logic             exp_last;
    logic             key_accept;
    logic             blk_accept;

    assign key_accept = key_load && ((state == NOKEY) || (state == READY));
    assign key_ready  = (state == READY);
    assign in_ready   = (state == READY) && !key_load;
    assign blk_accept = in_valid && in_ready;
    assign out_valid  = (state == DONE);

    simon_key_expand u_key_expand (
        .clk    (clk),
        .rst    (rst),
        .load   (key_accept),
        .key_in (key_in),
        .step   (state == EXPAND),
        .last   (exp_last),
        .rd_idx (r),
        .rd_key (rk_cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NOKEY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NOKEY:   if (key_load)   state_nxt = EXPAND;
            EXPAND:  if (exp_last)   state_nxt = READY;
            READY: begin
                if (key_load)        state_nxt = EXPAND;
                else if (in_valid)   state_nxt = DECRYPT;
            end
            DECRYPT: if (r == '0)    state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = READY;
            default:                 state_nxt = NOKEY;
        endcase
    end

    // Round index counts down and parks at 0; it is reloaded on every accept.
    always_ff @(posedge clk) begin
        if (blk_accept) begin
            r <= idx_t'(N_ROUNDS - 1);
        end else if ((state == DECRYPT) && (r != '0)) begin
            r <= r - idx_t'(1);
        end
    end

    assign f_y = (rol(y, 1) & rol(y, 8)) ^ rol(y, 2);

    always_ff @(posedge clk) begin
`ifdef SIMON_DEC_ZEROIZE_EN
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if ((state == DONE) && out_ready) begin
            x <= '0;
            y <= '0;
        end else
`endif
        if (blk_accept) begin
            x <= in_data.l;
            y <= in_data.r;
        end else if (state == DECRYPT) begin
            x <= y;
            y <= x ^ f_y ^ rk_cur;
        end
    end

`ifdef SIMON_DEC_ZEROIZE_EN
    assign out_data = out_valid ? {x, y} : '0;
`else
    assign out_data = {x, y};
`endif

endmodule

// File: tb/tb_simon_decrypt.sv
// Self-checking bench for simon_decrypt: known answer, table of random keys,
// hold/backpressure, key-vs-block collision, mid-decrypt reset, back-to-back.
module tb_simon_decrypt;
    import simon_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    key_t  key_in;
    logic  key_load;
    logic  key_ready;
    data_t in_data;
    logic  in_valid;
    logic  in_ready;
    data_t out_data;
    logic  out_valid;
    logic  out_ready;

    always #5 clk = ~clk;

    simon_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_load  (key_load),
        .key_ready (key_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // ---------------- reference model (plain Simon 64/96) ----------------
    string       z2 = "10101111011100000011010010011000101000010001111110010110110011";
    logic [31:0] m_ks [42];

    function automatic logic [31:0] mrol(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] mror(input logic [31:0] v, input int s);
        return (v >> s) | (v << (32 - s));
    endfunction

    function automatic void m_expand(input key_t k);
        logic [31:0] zc;
        for (int i = 0; i < 3; i++) m_ks[i] = k[i];
        for (int i = 3; i < 42; i++) begin
            zc = (z2[i-3] == "1") ? 32'd1 : 32'd0;
            m_ks[i] = 32'hFFFF_FFFC ^ zc ^ m_ks[i-3]
                      ^ mror(m_ks[i-1], 3) ^ mror(m_ks[i-1], 4);
        end
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] pt);
        logic [31:0] a, b, t;
        a = pt[63:32];
        b = pt[31:0];
        for (int i = 0; i < 42; i++) begin
            t = a;
            a = b ^ (mrol(a, 1) & mrol(a, 8)) ^ mrol(a, 2) ^ m_ks[i];
            b = t;
        end
        return {a, b};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input key_t k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_key_ready(output int n);
        n = 0;
        while (!key_ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Sends one block; returns cycles from accept edge to out_valid.
    // junk_key pulses key_load with a foreign key while the block is in flight.
    task automatic send_block(input logic [63:0] ct, input bit junk_key, output int lat);
        int n;
        in_data  = ct;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        if (junk_key) begin
            key_in   = {$urandom, $urandom, $urandom};
            key_load = 1'b1;
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        key_load = 1'b0;
    endtask

    task automatic take_output();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        key_t        key;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    vec_t        tv [4];
    key_t        k;
    logic [63:0] pt, ct;
    int          n, lat, seen, t_hs, t_out;

    initial begin
        rst       = 1'b1;
        key_in    = '0;
        key_load  = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Vector table: published known answer, then random keys via the model.
        tv[0].key = {32'h13121110, 32'h0b0a0908, 32'h03020100};
        tv[0].ct  = {32'h5ca2e27f, 32'h111a8fc8};
        tv[0].pt  = {32'h6f722067, 32'h6e696c63};
        m_expand(tv[0].key);
        chk("model_kat", m_encrypt(tv[0].pt), tv[0].ct);
        for (int i = 1; i < 4; i++) begin
            tv[i].key = {$urandom, $urandom, $urandom};
            tv[i].pt  = {$urandom, $urandom};
            m_expand(tv[i].key);
            tv[i].ct  = m_encrypt(tv[i].pt);
        end

        // Reset state
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_key_ready", 64'(key_ready), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
`ifdef SIMON_DEC_ZEROIZE_EN
        chk("rst_out_zero", out_data, 64'd0);
`endif

        // Table-driven vectors
        for (int i = 0; i < 4; i++) begin
            load_key(tv[i].key);
            wait_key_ready(n);
            chk("expand_cycles", 64'(n), 64'd39);
            send_block(tv[i].ct, 1'b0, lat);
            chk("latency", 64'(lat), 64'd42);
            chk("plaintext", out_data, tv[i].pt);
            take_output();
            chk("out_valid_after_hs", 64'(out_valid), 64'd0);
`ifdef SIMON_DEC_ZEROIZE_EN
            chk("hs_out_zero", out_data, 64'd0);
`endif
        end

        // Hold in DONE for 10 cycles with a pending new block
        load_key(tv[0].key);
        wait_key_ready(n);
        send_block(tv[0].ct, 1'b0, lat);
        chk("kat_latency", 64'(lat), 64'd42);
        in_data  = tv[1].ct;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, tv[0].pt);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        take_output();
        chk("hold_released", 64'(out_valid), 64'd0);

        // key_load and in_valid together in READY: key wins
        chk("ready_before_collide", 64'(key_ready), 64'd1);
        key_in   = tv[1].key;
        key_load = 1'b1;
        in_data  = tv[1].ct;
        in_valid = 1'b1;
        #1;
        chk("collide_in_ready", 64'(in_ready), 64'd0);
        tick();
        key_load = 1'b0;
        in_valid = 1'b0;
        chk("collide_key_ready", 64'(key_ready), 64'd0);
        wait_key_ready(n);
        chk("collide_expand", 64'(n), 64'd39);
        chk("collide_no_output", 64'(out_valid), 64'd0);
        // key_load during DECRYPT/DONE must not disturb the block or key
        send_block(tv[1].ct, 1'b1, lat);
        chk("junkkey_latency", 64'(lat), 64'd42);
        chk("junkkey_plain", out_data, tv[1].pt);
        take_output();
        chk("junkkey_ready", 64'(key_ready), 64'd1);
        send_block(tv[1].ct, 1'b0, lat);
        chk("key_kept_plain", out_data, tv[1].pt);
        take_output();

        // Reset in the middle of DECRYPT
        load_key(tv[2].key);
        wait_key_ready(n);
        in_data  = tv[2].ct;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 21; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_key_ready", 64'(key_ready), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd0);
`ifdef SIMON_DEC_ZEROIZE_EN
        chk("midrst_out_zero", out_data, 64'd0);
`endif
        in_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (in_ready || out_valid || key_ready) seen++;
            tick();
        end
        in_valid = 1'b0;
        chk("nokey_idle", 64'(seen), 64'd0);
        load_key(tv[2].key);
        wait_key_ready(n);
        chk("rekey_expand", 64'(n), 64'd39);
        send_block(tv[2].ct, 1'b0, lat);
        chk("rekey_plain", out_data, tv[2].pt);
        take_output();

        // Back-to-back blocks with out_ready held high
        k = {$urandom, $urandom, $urandom};
        m_expand(k);
        load_key(k);
        wait_key_ready(n);
        out_ready = 1'b1;
        t_hs = 0;
        for (int b = 0; b < 5; b++) begin
            pt = {$urandom, $urandom};
            ct = m_encrypt(pt);
            in_data  = ct;
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 200) begin
                tick();
                n++;
            end
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 200) begin
                tick();
                n++;
            end
            t_out = cyc;
            chk("b2b_plain", out_data, pt);
            if (b > 0) chk("b2b_interval", 64'(t_out - t_hs), 64'd43);
            tick();
            t_hs = cyc;
            chk("b2b_hs", 64'(out_valid), 64'd0);
`ifdef SIMON_DEC_ZEROIZE_EN
            chk("b2b_out_zero", out_data, 64'd0);
`endif
        end
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
